// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared state encoding and pin widths for the GPIO bank arbiter.
package gpio_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, MANUAL = 2'd2} state_e;
    localparam int GPIO1_WIDTH = 41;
    localparam int LED_WIDTH = 9;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer plus stability counter for a vector of raw switches.
module sw_debounce #(
    parameter int WIDTH = 9,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0] s1_q, s2_q, cand_q, db_q;
    logic [CW-1:0]    cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q <= sw_i;
            s2_q <= s1_q;
            if (s2_q != cand_q) begin
                cand_q <= s2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
    assign sw_o = db_q;
endmodule

// File: rtl/gpio_bank_arbiter.sv
// gpio_bank_arbiter: round-robin sharing of the LED/GPIO1 bank between NREQ requesters,
// with hold timeout/lockout and a debounced manual switch override.
module gpio_bank_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_HOLD = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8:0]             sw,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]        grant,
    output logic [LED_WIDTH-1:0]   led,
    output logic [GPIO1_WIDTH-1:0] gpio1,
    output logic                   timeout_err
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD);
    localparam int LW = LED_WIDTH - 1;
    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, w_q, w_d, win, idx;
    logic [HW-1:0]    hold_q, hold_d;
    logic [NREQ-1:0]  grant_q, grant_d, lock_q, lock_d, elig;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d, found, timeout;
    logic [8:0]       dbs;

    sw_debounce #(.WIDTH(9), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk (clk),
        .rst (rst),
        .sw_i(sw),
        .sw_o(dbs)
    );

    always_comb begin
        elig  = req & ~lock_q;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        // First eligible requester at or after the pointer, wrapping.
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        out_d   = out_q;
        err_d   = err_q;
        lock_d  = lock_q & req;
        timeout = req[w_q] && hold_q == HW'(MAX_HOLD - 1);
        if (dbs[8]) begin
            state_d = MANUAL;
            grant_d = '0;
            hold_d  = '0;
            out_d   = WIDTH'(dbs[7:0]);
        end else if (state_q == IDLE) begin
            out_d = '0;
            if (found) begin
                state_d      = GRANT;
                grant_d      = '0;
                grant_d[win] = 1'b1;
                w_d          = win;
                hold_d       = '0;
            end
        end else if (state_q == GRANT) begin
            out_d  = req_data[int'(w_q)*WIDTH +: WIDTH];
            hold_d = hold_q + HW'(1);
            if (!req[w_q] || timeout) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = PW'((int'(w_q) + 1) % NREQ);
            end
            if (timeout) begin
                lock_d[w_q] = 1'b1;
                err_d       = 1'b1;
            end
        end else begin
            state_d = IDLE;
            grant_d = '0;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            lock_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign grant       = grant_q;
    assign led         = {state_q == MANUAL, LW'(out_q)};
    assign gpio1       = GPIO1_WIDTH'(out_q);
    assign timeout_err = err_q;
endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// tb_gpio_bank_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_gpio_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  sw = '0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic [3:0]  grant;
    logic [8:0]  led;
    logic [40:0] gpio1;
    logic        timeout_err;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] g;
        logic [8:0] l;
        logic       e;
    } vec_t;
    vec_t tbl[$];

    gpio_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEBOUNCE_CYCLES(4), .MAX_HOLD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .led        (led),
        .gpio1      (gpio1),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic [8:0] l, input logic e);
        chk({nm, ".grant"}, 64'(grant), 64'(g));
        chk({nm, ".led"}, 64'(led), 64'(l));
        chk({nm, ".gpio1"}, 64'(gpio1), {56'b0, l[7:0]});
        chk({nm, ".err"}, 64'(timeout_err), 64'(e));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        sw  = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        // Latency: grant one edge after req, data one edge after grant.
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 9'h0A5, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 9'h0A5, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 9'h000, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 9'h000, 1'b0});
        // Round robin 0,1,2,3,0 with a one-cycle idle gap between grants.
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 9'h011, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 9'h011, 1'b0});
        tbl.push_back('{1'b0, 4'b1110, 4'b0000, 9'h011, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 9'h022, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 9'h022, 1'b0});
        tbl.push_back('{1'b0, 4'b1101, 4'b0000, 9'h022, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100, 9'h0A5, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0100, 9'h0A5, 1'b0});
        tbl.push_back('{1'b0, 4'b1011, 4'b0000, 9'h0A5, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000, 9'h044, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000, 9'h044, 1'b0});
        tbl.push_back('{1'b0, 4'b0111, 4'b0000, 9'h044, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 9'h000, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 9'h011, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 9'h000, 1'b0});

        tick;
        chk_out("reset", 4'b0000, 9'h000, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            tick;
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].l, tbl[i].e);
        end

        // Timeout: pointer is 1, req[1] held ~20 cycles alongside req[3].
        req = 4'b1010;
        tick;
        chk("to.grant1", 64'(grant), 64'b0010);
        for (int i = 1; i < 8; i++) begin
            tick;
            chk($sformatf("to.hold%0d", i), 64'(grant), 64'b0010);
        end
        tick;
        chk("to.revoke", 64'(grant), 64'b0000);
        chk("to.err", 64'(timeout_err), 64'd1);
        tick;
        chk("to.grant3", 64'(grant), 64'b1000);
        req = 4'b0010;
        tick;
        chk("to.rel3", 64'(grant), 64'b0000);
        for (int i = 0; i < 9; i++) begin
            tick;
            chk($sformatf("to.locked%0d", i), 64'(grant), 64'b0000);
        end
        req = 4'b0000;
        tick;
        chk("to.drop", 64'(grant), 64'b0000);
        req = 4'b0010;
        tick;
        chk("to.regrant1", 64'(grant), 64'b0010);
        chk("to.err_sticky", 64'(timeout_err), 64'd1);
        req = 4'b0000;
        tick;
        tick;

        // Glitch on sw[8] is ignored; a held 9'h13C enters manual mode.
        do_reset;
        sw = 9'h100;
        tick;
        tick;
        sw = 9'h000;
        repeat (10) tick;
        chk("glitch.led", 64'(led), 64'h000);
        sw = 9'h13C;
        repeat (5) tick;
        chk("man.early", 64'(led[8]), 64'd0);
        for (int k = 0; k < 10 && !led[8]; k++) tick;
        chk("man.led", 64'(led), 64'h13C);
        chk("man.gpio1", 64'(gpio1), 64'h3C);
        chk("man.grant", 64'(grant), 64'h0);
        sw = 9'h000;
        for (int k = 0; k < 15 && led[8]; k++) tick;
        chk("man.exit", 64'(led), 64'h000);

        // Manual preempts grant[2]; pointer stays at 2 so 2 wins again over 1.
        do_reset;
        req = 4'b0010;
        tick;
        chk("pre.g1", 64'(grant), 64'b0010);
        req = 4'b0000;
        tick;
        tick;
        sw = 9'h100;
        tick;
        tick;
        req = 4'b0110;
        tick;
        chk("pre.g2", 64'(grant), 64'b0100);
        for (int k = 0; k < 12 && !led[8]; k++) tick;
        chk("pre.man_led", 64'(led), 64'h100);
        chk("pre.man_grant", 64'(grant), 64'b0000);
        sw = 9'h000;
        for (int k = 0; k < 20 && grant == 4'b0000; k++) tick;
        chk("pre.regrant", 64'(grant), 64'b0100);
        chk("pre.led8", 64'(led[8]), 64'd0);
        req = 4'b0000;
        tick;
        tick;

        // Reset mid-grant with a sticky error clears everything in one edge.
        do_reset;
        req = 4'b0011;
        for (int k = 0; k < 30 && grant != 4'b0010; k++) tick;
        chk("rst.pre_grant", 64'(grant), 64'b0010);
        chk("rst.pre_err", 64'(timeout_err), 64'd1);
        rst = 1'b1;
        tick;
        chk_out("rst.mid", 4'b0000, 9'h000, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpio_bank_arbiter.md
Name: gpio_bank_arbiter

Overview:
- Shares the board's 8-bit LED/GPIO1 output bank between NREQ internal requesters, such as PID debug taps and laser drive monitors.
- Grants are round-robin with a request/grant handshake and a hold timeout.
- A debounced sw[8] override gives manual bench control: sw[7:0] drives the bank directly.
- Sits between the datapath blocks and the top-level led/gpio1 pins.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: data width driven onto led[7:0] / gpio1[7:0].
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a switch change is accepted (10 ms at 50 MHz).
- MAX_HOLD, 1024: maximum grant length in cycles before forced revoke.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  9  raw board switches; [8] manual override, [7:0] manual data
- req  in  NREQ  per-requester request, level
- req_data  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot grant, registered
- led  out  9  [7:0] bank data, [8] manual-mode indicator
- gpio1  out  41  [7:0] bank data, [40:8] driven 0
- timeout_err  out  1  sticky, set on any forced revoke

Behaviour:
- Reset values: grant=0, led=0, gpio1=0, timeout_err=0, state=IDLE, rr pointer=0, lockout=0, hold counter=0, debounced switches=0, debounce counter=0.
- Clock and reset: one clock domain; reset is synchronous and active-high, as already decided.
- Switch path:
  - 2-flop synchronizer on all 9 switches.
  - Any change in the synchronized 9-bit vector relative to the candidate restarts the counter.
  - The debounced value updates after DEBOUNCE_CYCLES consecutive equal samples.
- States: IDLE, GRANT, MANUAL. Bank output register `out` feeds led[7:0] and gpio1[7:0].
- IDLE:
  - out <= 0.
  - Eligible requester: req[i]=1 and lockout[i]=0.
  - Winner: first eligible index at or after the pointer, wrapping modulo NREQ.
  - On a win: next cycle grant[w]=1, state=GRANT, hold=0.
- GRANT:
  - out <= req_data[w] every cycle. Data presented in cycle k appears on pins in cycle k+1.
  - Latency: req sampled in cycle N -> grant in N+1 -> first data on pins in N+2.
  - Release: req[w] sampled low -> next cycle grant=0, pointer=(w+1)%NREQ, state=IDLE.
  - A release always passes through at least one IDLE cycle; there are no back-to-back grants.
  - Hold counter increments each GRANT cycle. If hold reaches MAX_HOLD-1 with req[w] still high:
    - forced revoke, same as release;
    - lockout[w]=1 and timeout_err=1.
  - lockout[i] clears the cycle after req[i] is sampled low.
- MANUAL:
  - Entered from any state the cycle after debounced sw[8]=1; this has priority over all requests.
  - grant=0; out <= debounced sw[7:0]; led[8]=1.
  - A grant preempted by MANUAL leaves the pointer unchanged, so the preempted requester wins first if still requesting.
  - Debounced sw[8]=0 -> IDLE.
- led[8]=1 only in MANUAL.
- Simultaneous release and new requests: handled by the bubble rule; the new winner is evaluated in IDLE with the updated pointer.
- Timeout in the same cycle as req deasserting: treated as a normal release, no error.
- All requests locked out: remain in IDLE.
- rst asserted mid-grant: grant drops and everything returns to reset values the next edge.

Decomposition:
- Package gpio_arb_pkg:
  - state encoding localparams (IDLE=2'd0, GRANT=2'd1, MANUAL=2'd2);
  - GPIO1_WIDTH=41;
  - LED_WIDTH=9.
- Sub-module sw_debounce:
  - synchronizer plus stability counter;
  - parameterized by width and DEBOUNCE_CYCLES;
  - instantiated once for the 9-bit switch vector.

Test Plan (bench uses DEBOUNCE_CYCLES=4, MAX_HOLD=8, NREQ=4):
- Reset, then req=4'b0100 with data2=8'hA5 -> grant=4'b0100 one cycle later; led[7:0]=gpio1[7:0]=8'hA5 the cycle after; gpio1[40:8]=0.
- req=4'b1111 held, each requester dropping req 3 cycles after its grant -> grant order 0,1,2,3,0 with exactly one idle (out=0) cycle between grants.
- req[1] held high for 20 cycles -> grant[1] revoked after 8 GRANT cycles; timeout_err=1; req[1] not re-granted until it drops low for a cycle; req[3] granted in the interim.
- sw[8] glitches high for 2 cycles -> no mode change. Then sw=9'h13C held -> after sync plus 4 stable cycles: MANUAL, led=9'h13C, gpio1[7:0]=8'h3C, grant=0.
- During grant[2], sw[8] goes stable high -> grant[2] drops, MANUAL entered. sw[8] returns low with req[2] still high -> IDLE, then grant[2] again, since the pointer was unchanged.
- Reset asserted mid-GRANT with timeout_err=1 -> next edge: grant=0, led=0, gpio1=0, timeout_err=0.
